// File: rtl/cpu_pkg.sv
// Types and helpers shared by the processor top and the program sequencer.
// Instruction word layout: opcode[8:6], X[5:3], Y[2:0].
package cpu_pkg;

   localparam int WORD_W = 9;
   localparam int OPC_W  = 3;

   typedef enum logic [OPC_W-1:0] {
      OP_DISP = 3'b000,
      OP_MOV  = 3'b001,
      OP_ADDI = 3'b010,
      OP_ADD  = 3'b011,
      OP_SUB  = 3'b100,
      OP_AND  = 3'b101,
      OP_OR   = 3'b110,
      OP_MOVI = 3'b111
   } opcode_t;

   typedef enum logic [1:0] {
      SEQ_IDLE,
      SEQ_RUN,
      SEQ_PAUSE,
      SEQ_HALT
   } seq_state_t;

   // Opcodes whose following program word is immediate data, not an instruction.
   function automatic logic needs_imm(input opcode_t op);
      return (op == OP_ADDI) || (op == OP_MOVI);
   endfunction

endpackage

// File: rtl/prog_mem.sv
// Program store: synchronous write, asynchronous read, write-first bypass so a
// word being written is visible on the read port in the same cycle.
module prog_mem #(
   parameter int ADDR_W = 5,
   parameter int WORD_W = cpu_pkg::WORD_W
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [WORD_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [WORD_W-1:0] rdata_o
);

   logic [WORD_W-1:0] mem_q [2**ADDR_W];

   // NOTE: the array has no reset; clearing it would turn it into a large flop bank.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];

endmodule

// File: rtl/prog_sequencer.sv
// Feeds the CPU instruction port from a loadable program store and gates the
// CPU tick enable for run, single-step and halt control.
module prog_sequencer #(
   parameter int ADDR_W = 5,
   parameter int WORD_W = cpu_pkg::WORD_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load_en,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [WORD_W-1:0] load_data,
   input  logic [ADDR_W-1:0] prog_last,
   input  logic              run,
   input  logic              step_mode,
   input  logic              step,
   input  logic              cpu_fetch,
   input  logic              cpu_done,
   output logic [WORD_W-1:0] din,
   output logic              tick_ena,
   output logic [ADDR_W-1:0] pc,
   output logic              halted
);

   import cpu_pkg::*;

   seq_state_t        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] last_q, last_d;
   logic              seen_q, seen_d;
   logic              imm_q, imm_d;
   logic [WORD_W-1:0] word;
   logic              mem_we;
   opcode_t           word_op;

   // The store may only change while the CPU is not consuming it.
   assign mem_we = load_en && ((state_q == SEQ_IDLE) || (state_q == SEQ_HALT));

   prog_mem #(
      .ADDR_W (ADDR_W),
      .WORD_W (WORD_W)
   ) u_mem (
      .clk     (clk),
      .we_i    (mem_we),
      .waddr_i (load_addr),
      .wdata_i (load_data),
      .raddr_i (pc_q),
      .rdata_o (word)
   );

   assign word_op = opcode_t'(word[WORD_W-1 -: OPC_W]);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SEQ_IDLE;
         pc_q    <= '0;
         last_q  <= '0;
         seen_q  <= 1'b0;
         imm_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         last_q  <= last_d;
         seen_q  <= seen_d;
         imm_q   <= imm_d;
      end
   end

   // NOTE: every next-state signal gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      last_d  = last_q;
      seen_d  = seen_q;
      imm_d   = imm_q;

      unique case (state_q)
         SEQ_IDLE, SEQ_HALT: begin
            if (run) begin
               state_d = SEQ_RUN;
               pc_d    = '0;
               last_d  = prog_last;
               seen_d  = 1'b0;
               imm_d   = 1'b0;
            end
         end
         SEQ_RUN: begin
            if (cpu_fetch) begin
               pc_d = pc_q + ADDR_W'(1);
               if (pc_q == last_q) begin
                  seen_d = 1'b1;
               end
               if (imm_q) begin
                  imm_d = 1'b0;
               end else if (needs_imm(word_op)) begin
                  imm_d = 1'b1;
               end
            end
            // A fetch in the same cycle is accounted for before judging cpu_done.
            if (cpu_done && !imm_d) begin
               if (seen_d) begin
                  state_d = SEQ_HALT;
               end else if (step_mode) begin
                  state_d = SEQ_PAUSE;
               end
            end
         end
         SEQ_PAUSE: begin
            if (step) begin
               state_d = SEQ_RUN;
            end
         end
         default: state_d = SEQ_IDLE;
      endcase
   end

   assign tick_ena = (state_q == SEQ_RUN);
   assign din      = tick_ena ? word : '0;
   assign pc       = pc_q;
   assign halted   = (state_q == SEQ_HALT);

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: a per-cycle reference model of the sequencing rules
// checked every cycle, plus literal expectations for the directed scenarios.
module tb_prog_sequencer;

   localparam int AW   = 5;
   localparam int SAW  = 2;
   localparam int NW   = 32;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_HALT  = 3;

   logic          clk = 1'b0;
   logic          rst;

   // main instance (5-bit address)
   logic          load_en, run, step_mode, step, cpu_fetch, cpu_done;
   logic [AW-1:0] load_addr, prog_last;
   logic [8:0]    load_data;
   logic [8:0]    din;
   logic          tick_ena, halted;
   logic [AW-1:0] pc;

   // small instance (2-bit address, exercises pc wrap)
   logic           s_load_en, s_run, s_fetch, s_done;
   logic [SAW-1:0] s_load_addr, s_prog_last;
   logic [8:0]     s_load_data;
   logic [8:0]     s_din;
   logic           s_tick, s_halted;
   logic [SAW-1:0] s_pc;

   int n_checks = 0;
   int n_fail   = 0;
   bit cmp_en   = 0;

   // reference model state
   int         m_mode = M_IDLE;
   int         m_pc   = 0;
   int         m_end  = 0;
   bit         m_seen = 0;
   bit         m_imm  = 0;
   logic [8:0] m_store [NW];

   prog_sequencer #(.ADDR_W(AW)) dut (
      .clk       (clk),
      .rst       (rst),
      .load_en   (load_en),
      .load_addr (load_addr),
      .load_data (load_data),
      .prog_last (prog_last),
      .run       (run),
      .step_mode (step_mode),
      .step      (step),
      .cpu_fetch (cpu_fetch),
      .cpu_done  (cpu_done),
      .din       (din),
      .tick_ena  (tick_ena),
      .pc        (pc),
      .halted    (halted)
   );

   prog_sequencer #(.ADDR_W(SAW)) dut_small (
      .clk       (clk),
      .rst       (rst),
      .load_en   (s_load_en),
      .load_addr (s_load_addr),
      .load_data (s_load_data),
      .prog_last (s_prog_last),
      .run       (s_run),
      .step_mode (1'b0),
      .step      (1'b0),
      .cpu_fetch (s_fetch),
      .cpu_done  (s_done),
      .din       (s_din),
      .tick_ena  (s_tick),
      .pc        (s_pc),
      .halted    (s_halted)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit is_imm_op(input logic [8:0] w);
      return (w[8:6] == 3'd2) || (w[8:6] == 3'd7);
   endfunction

   // Reference model: applies the sequencing rules to the inputs seen at each edge.
   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_mode = M_IDLE;
            m_pc   = 0;
            m_seen = 0;
            m_imm  = 0;
         end else begin
            case (m_mode)
               M_IDLE, M_HALT: begin
                  if (load_en) m_store[load_addr] = load_data;
                  if (run) begin
                     m_mode = M_RUN;
                     m_pc   = 0;
                     m_end  = int'(prog_last);
                     m_seen = 0;
                     m_imm  = 0;
                  end
               end
               M_RUN: begin
                  if (cpu_fetch) begin
                     if (m_imm) m_imm = 0;
                     else       m_imm = is_imm_op(m_store[m_pc]);
                     if (m_pc == m_end) m_seen = 1;
                     m_pc = (m_pc + 1) % NW;
                  end
                  if (cpu_done && !m_imm) begin
                     if (m_seen)         m_mode = M_HALT;
                     else if (step_mode) m_mode = M_PAUSE;
                  end
               end
               M_PAUSE: if (step) m_mode = M_RUN;
               default: m_mode = M_IDLE;
            endcase
         end
      end
   end

   // Compare process: all outputs against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (cmp_en) begin
            check("cmp_din",    32'(din),      (m_mode == M_RUN) ? 32'(m_store[m_pc]) : 32'd0);
            check("cmp_tick",   32'(tick_ena), 32'(m_mode == M_RUN));
            check("cmp_pc",     32'(pc),       32'(m_pc));
            check("cmp_halted", 32'(halted),   32'(m_mode == M_HALT));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cyc(input logic f, input logic d);
      cpu_fetch = f;
      cpu_done  = d;
      tick();
      cpu_fetch = 1'b0;
      cpu_done  = 1'b0;
   endtask

   task automatic instr();
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b1);
   endtask

   task automatic load(input int a, input int dat);
      load_en   = 1'b1;
      load_addr = a[AW-1:0];
      load_data = dat[8:0];
      tick();
      load_en   = 1'b0;
   endtask

   task automatic start(input int last);
      prog_last = last[AW-1:0];
      run       = 1'b1;
      tick();
      run       = 1'b0;
   endtask

   task automatic s_cyc(input logic f, input logic d);
      s_fetch = f;
      s_done  = d;
      tick();
      s_fetch = 1'b0;
      s_done  = 1'b0;
   endtask

   task automatic s_load(input int a, input int dat);
      s_load_en   = 1'b1;
      s_load_addr = a[SAW-1:0];
      s_load_data = dat[8:0];
      tick();
      s_load_en   = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      {load_en, run, step_mode, step, cpu_fetch, cpu_done} = '0;
      load_addr = '0; load_data = '0; prog_last = '0;
      {s_load_en, s_run, s_fetch, s_done} = '0;
      s_load_addr = '0; s_load_data = '0; s_prog_last = '0;
      repeat (2) tick();
      check("rst_pc", 32'(pc), 0);
      check("rst_din", 32'(din), 0);
      check("rst_tick", 32'(tick_ena), 0);
      check("rst_halted", 32'(halted), 0);
      rst    = 1'b0;
      cmp_en = 1;

      // run together with a write to address 0: write lands, run accepted
      load_en = 1'b1; load_addr = '0; load_data = 9'h123; prog_last = '0; run = 1'b1;
      tick();
      load_en = 1'b0; run = 1'b0;
      check("wf_din", 32'(din), 32'h123);
      check("wf_tick", 32'(tick_ena), 1);
      instr();
      check("wf_halted", 32'(halted), 1);

      // MOVI + immediate + DISP
      load(0, 9'h1C0);
      load(1, 9'h005);
      load(2, 9'h000);
      start(2);
      check("t1_din0", 32'(din), 32'h1C0);
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b1);
      check("t1_din1", 32'(din), 32'h005);
      check("t1_imm_ignored", 32'(tick_ena), 1);
      instr();
      check("t1_din2", 32'(din), 32'h000);
      check("t1_not_yet", 32'(halted), 0);
      instr();
      check("t1_halted", 32'(halted), 1);
      check("t1_pc", 32'(pc), 3);
      check("t1_tick", 32'(tick_ena), 0);

      // rerun from HALT with a shorter program
      start(1);
      check("t6_halted_drop", 32'(halted), 0);
      check("t6_pc", 32'(pc), 0);
      instr();
      check("t6_mid", 32'(halted), 0);
      instr();
      check("t6_halted", 32'(halted), 1);
      check("t6_pc_end", 32'(pc), 2);

      // load and run attempts while running are dropped
      load(3, 9'h011);
      load(4, 9'h022);
      start(2);
      cyc(1'b1, 1'b0);
      load_en = 1'b1; load_addr = 5'd4; load_data = 9'h1FF; run = 1'b1;
      tick();
      load_en = 1'b0; run = 1'b0;
      check("t3_run_ignored", 32'(pc), 1);
      cyc(1'b0, 1'b1);
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b1);
      instr();
      check("t3_halt", 32'(halted), 1);
      step = 1'b1;
      tick();
      step = 1'b0;
      check("t3_step_in_halt", 32'(halted), 1);
      start(4);
      cyc(1'b1, 1'b0);
      cyc(1'b1, 1'b0);
      cyc(1'b0, 1'b1);
      instr();
      check("t3_din3", 32'(din), 32'h011);
      instr();
      check("t3_store4", 32'(din), 32'h022);
      instr();
      check("t3_halted", 32'(halted), 1);
      check("t3_pc", 32'(pc), 5);

      // single-step mode
      load(0, 9'h008);
      load(1, 9'h011);
      load(2, 9'h03A);
      step_mode = 1'b1;
      start(2);
      check("t2_din0", 32'(din), 32'h008);
      instr();
      check("t2_pause_tick", 32'(tick_ena), 0);
      check("t2_pause_din", 32'(din), 0);
      check("t2_pause_pc", 32'(pc), 1);
      step_mode = 1'b0;
      repeat (2) tick();
      check("t2_no_resume", 32'(tick_ena), 0);
      step_mode = 1'b1;
      step = 1'b1;
      tick();
      step = 1'b0;
      check("t2_resume_tick", 32'(tick_ena), 1);
      check("t2_resume_din", 32'(din), 32'h011);
      instr();
      check("t2_pc2", 32'(pc), 2);
      check("t2_paused2", 32'(tick_ena), 0);
      step = 1'b1;
      tick();
      step = 1'b0;
      instr();
      check("t2_halt_prio", 32'(halted), 1);
      check("t2_pc3", 32'(pc), 3);
      step_mode = 1'b0;

      // reset in the middle of a run
      start(2);
      instr();
      instr();
      check("t5_pc2", 32'(pc), 2);
      check("t5_running", 32'(tick_ena), 1);
      #2 rst = 1'b1;
      #1;
      check("t5_rst_tick", 32'(tick_ena), 0);
      check("t5_rst_pc", 32'(pc), 0);
      check("t5_rst_din", 32'(din), 0);
      tick();
      rst = 1'b0;
      start(2);
      check("t5_refetch", 32'(din), 32'h008);
      instr();
      check("t5_din1", 32'(din), 32'h011);
      instr();
      instr();
      check("t5_halted", 32'(halted), 1);

      // 2-bit address instance: immediate of the last word wraps to address 0
      s_load(0, 9'h005);
      s_load(1, 9'h008);
      s_load(2, 9'h010);
      s_load(3, 9'h089);
      s_prog_last = 2'd3;
      s_run = 1'b1;
      tick();
      s_run = 1'b0;
      check("w_din0", 32'(s_din), 32'h005);
      repeat (3) begin
         s_cyc(1'b1, 1'b0);
         s_cyc(1'b0, 1'b1);
      end
      check("w_pc3", 32'(s_pc), 3);
      check("w_din3", 32'(s_din), 32'h089);
      s_cyc(1'b1, 1'b0);
      check("w_pc_wrap", 32'(s_pc), 0);
      s_cyc(1'b0, 1'b1);
      check("w_not_halted", 32'(s_halted), 0);
      check("w_imm_din", 32'(s_din), 32'h005);
      s_cyc(1'b1, 1'b0);
      s_cyc(1'b0, 1'b1);
      check("w_halted", 32'(s_halted), 1);
      check("w_pc_end", 32'(s_pc), 1);
      check("w_tick", 32'(s_tick), 0);

      tick();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
